term_write_ctrl: RTL
====================

// Module: term_write_ctrl
// PURPOSE
//  Sequences the serial terminal's write position: consumes received bytes, writes printable
//  characters into text RAM, handles CR/LF/BS/FF, and scrolls by ring-buffer row offset.
//  Drives the cursor block's write-cell coordinates and cursor height.
//  Sits between the UART receiver and the text RAM write port.
// PARAMETERS
//  COLS      40   text columns (<=64, fits 6-bit x)
//  ROWS      30   text rows (<=32, fits 5-bit y)
//  CURSOR_H  1    default cursor height, 0..15 (0 = bottom line only)
// PORTS
//  i_clk        in   1   pixel/system clock, single clock domain
//  i_rst        in   1   synchronous, active-high reset
//  i_rx_data    in   8   received byte
//  i_rx_valid   in   1   i_rx_data valid
//  o_rx_ready   out  1   controller can accept a byte (high only in IDLE)
//  o_wr_en      out  1   text RAM write strobe
//  o_wr_addr    out  11  text RAM address = phys_row*COLS + col
//  o_wr_data    out  8   text RAM write data
//  o_wr_cell_x  out  6   logical cursor column (to cursor block)
//  o_wr_cell_y  out  5   logical cursor row (to cursor block)
//  o_scroll     out  5   row offset; display maps logical row r to physical (r+o_scroll) mod ROWS
//  o_cursor_h   out  4   cursor height (to cursor block i_h)
// BEHAVIOUR
//  States: IDLE, EXEC, CLR. Byte accepted on i_rx_valid & o_rx_ready (o_rx_ready = state==IDLE),
//   latched; IDLE->EXEC. EXEC lasts exactly 1 cycle, then IDLE or CLR.
//  EXEC actions by latched byte b:
//   0x20..0x7E: o_wr_en=1, o_wr_data=b, o_wr_addr at current (x,y); then x++; if x was COLS-1,
//    x=0 and do NEWLINE.
//   0x0D CR: x=0.  0x0A LF: NEWLINE.  0x08 BS: x-- if x>0, else no-op (no erase).
//   0x0C FF: x=0, y=0, o_scroll=0, enter CLR(screen).  Any other byte: consumed, no effect.
//  NEWLINE: if y<ROWS-1, y++; else o_scroll=(o_scroll+1) mod ROWS, y stays ROWS-1, enter CLR(line)
//   on the new bottom physical row.
//  CLR: writes 0x20 once per cycle, ascending addresses; line = COLS writes starting at
//   phys_row*COLS, screen = ROWS*COLS writes from 0. Last write -> IDLE next cycle. No input accepted.
//  Physical row = (y+o_scroll) mod ROWS, computed by compare/subtract (no divider); addr fits 11 bits.
//  Reset: x=0, y=0, o_scroll=0, o_wr_en=0, o_cursor_h=CURSOR_H, state=CLR(screen): first cycle after
//   reset release writes address 0; o_rx_ready=0 until ROWS*COLS writes complete.
//  Reset asserted mid-CLR or mid-EXEC aborts the operation and restarts the full-screen clear.
//  o_wr_en is low in IDLE and in EXEC for non-printable bytes. Latency byte accept -> RAM write:
//   1 cycle. Peak throughput: 1 printable byte per 2 cycles.
// CONFIGURATION
//  `CURSOR_HEIGHT_CMD_EN defined: byte 0x0E arms height mode; the next accepted byte sets
//   o_cursor_h = byte[3:0] and is not printed. Arm persists across cycles until that byte arrives;
//   reset disarms.
//  Undefined: 0x0E is an ignored control byte; o_cursor_h constant CURSOR_H.
// STRUCTURE
//  term_pkg: control-code constants (BS, LF, FF, CR, SO), state encoding, COLS/ROWS defaults,
//   blank char 0x20.
//  Sub-module term_addr_map: combinational (x, y, scroll) -> physical row and o_wr_addr.
//   Instantiated once; CLR uses its own counter for addresses.
// TESTING
//  Reset, hold i_rx_valid=0 -> 1200 writes of 0x20 to addr 0..1199, then o_rx_ready=1, x=y=0.
//  Send 'A' (0x41) at (0,0) -> one cycle later o_wr_en=1, addr 0, data 0x41; x=1.
//  40 printables on row 0 -> x wraps to 0, y=1; no write at column 40.
//  At y=29, o_scroll=0, send LF -> o_scroll=1, y=29, 40 blank writes to addr 0..39,
//   o_rx_ready low throughout.
//  BS at x=0 -> no write, x stays 0; CR at x=17 -> x=0; byte 0x07 -> no state change.
//  With CURSOR_HEIGHT_CMD_EN: 0x0E then 0x3F -> o_cursor_h=15, no RAM write; without: 0x0E ignored.

Source files
------------

// File: rtl/term_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// term_pkg : shared constants, FSM encoding and helpers for the terminal
//            write controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
package term_pkg;

  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SO    = 8'h0E;
  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CLR  = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_BLANK) && (b <= CH_TILDE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/term_addr_map.sv
`default_nettype none
// ---------------------------------------------------------------------------
// term_addr_map : maps logical (x, y) plus ring scroll offset to a text RAM
//                 address; the modulo is a single compare/subtract.
// Revision : 1.0
// ---------------------------------------------------------------------------
module term_addr_map #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic [5:0]  x_i,
  input  logic [4:0]  y_i,
  input  logic [4:0]  scroll_i,
  output logic [10:0] addr_o
);

  logic [5:0] sum;
  logic [4:0] phys_row;

  // y and scroll are both < ROWS, so one subtraction completes the modulo
  always_comb begin
    sum = {1'b0, y_i} + {1'b0, scroll_i};
    if (sum >= 6'(ROWS)) begin
      phys_row = 5'(sum - 6'(ROWS));
    end else begin
      phys_row = sum[4:0];
    end
    addr_o = ({6'd0, phys_row} * 11'(COLS)) + {5'd0, x_i};
  end

endmodule
`default_nettype wire

// File: rtl/term_write_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// term_write_ctrl : consumes UART bytes, writes text RAM, handles CR/LF/BS/FF
//                   and scrolls through a ring-buffer row offset.
// Option   : CURSOR_HEIGHT_CMD_EN enables the 0x0E cursor-height command.
// Revision : 1.0
// ---------------------------------------------------------------------------
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int CURSOR_H = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_wr_en,
  output logic [10:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic [5:0]  o_wr_cell_x,
  output logic [4:0]  o_wr_cell_y,
  output logic [4:0]  o_scroll,
  output logic [3:0]  o_cursor_h
);

`ifdef CURSOR_HEIGHT_CMD_EN
  localparam logic HCMD_EN = 1'b1;
`else
  localparam logic HCMD_EN = 1'b0;
`endif

  localparam logic [5:0]  X_LAST   = 6'(COLS - 1);
  localparam logic [4:0]  Y_LAST   = 5'(ROWS - 1);
  localparam logic [10:0] SCREEN_N = 11'(ROWS * COLS);
  localparam logic [10:0] LINE_N   = 11'(COLS);

  state_e      state_q;
  logic [7:0]  byte_q;
  logic [5:0]  x_q;
  logic [4:0]  y_q;
  logic [4:0]  scroll_q;
  logic        wr_en_q;
  logic [10:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [3:0]  cursor_h_q;
  logic [10:0] clr_base_q;
  logic [10:0] clr_n_q;
  logic [10:0] clr_cnt_q;
  logic        arm_q;
  logic        hcmd_q;

  logic [10:0] map_addr;

  logic [5:0]  x_d;
  logic [4:0]  y_d;
  logic [4:0]  scroll_d;
  logic        clr_go_d;
  logic        clr_screen_d;
  logic [10:0] clr_base_d;
  logic        newline;

  term_addr_map #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_addr_map (
    .x_i      (x_q),
    .y_i      (y_q),
    .scroll_i (scroll_q),
    .addr_o   (map_addr)
  );

  // Position update for the byte held in byte_q; only consumed in EXEC.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    scroll_d     = scroll_q;
    clr_go_d     = 1'b0;
    clr_screen_d = 1'b0;
    newline      = 1'b0;
    if (!hcmd_q) begin
      if (is_printable(byte_q)) begin
        if (x_q == X_LAST) begin
          x_d     = 6'd0;
          newline = 1'b1;
        end else begin
          x_d = x_q + 6'd1;
        end
      end else begin
        case (byte_q)
          CH_CR: x_d = 6'd0;
          CH_LF: newline = 1'b1;
          CH_BS: if (x_q != 6'd0) x_d = x_q - 6'd1;
          CH_FF: begin
            x_d          = 6'd0;
            y_d          = 5'd0;
            scroll_d     = 5'd0;
            clr_go_d     = 1'b1;
            clr_screen_d = 1'b1;
          end
          default: ;
        endcase
      end
      if (newline) begin
        if (y_q < Y_LAST) begin
          y_d = y_q + 5'd1;
        end else begin
          scroll_d = (scroll_q == Y_LAST) ? 5'd0 : scroll_q + 5'd1;
          clr_go_d = 1'b1;
        end
      end
    end
    // After a scroll the new bottom row lands on the old scroll offset.
    clr_base_d = clr_screen_d ? 11'd0 : ({6'd0, scroll_q} * LINE_N);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_CLR;
      byte_q     <= 8'd0;
      x_q        <= 6'd0;
      y_q        <= 5'd0;
      scroll_q   <= 5'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 11'd0;
      wr_data_q  <= CH_BLANK;
      cursor_h_q <= 4'(CURSOR_H);
      clr_base_q <= 11'd0;
      clr_n_q    <= SCREEN_N;
      clr_cnt_q  <= 11'd0;
      arm_q      <= 1'b0;
      hcmd_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          if (i_rx_valid) begin
            state_q   <= ST_EXEC;
            byte_q    <= i_rx_data;
            hcmd_q    <= HCMD_EN & arm_q;
            arm_q     <= HCMD_EN & ~arm_q & (i_rx_data == CH_SO);
            wr_en_q   <= ~(HCMD_EN & arm_q) & is_printable(i_rx_data);
            wr_addr_q <= map_addr;
            wr_data_q <= i_rx_data;
          end
        end
        ST_EXEC: begin
          x_q      <= x_d;
          y_q      <= y_d;
          scroll_q <= scroll_d;
          if (HCMD_EN && hcmd_q) begin
            cursor_h_q <= byte_q[3:0];
          end
          if (clr_go_d) begin
            // First blank is issued here so every CLR cycle carries a write.
            state_q    <= ST_CLR;
            wr_en_q    <= 1'b1;
            wr_addr_q  <= clr_base_d;
            wr_data_q  <= CH_BLANK;
            clr_base_q <= clr_base_d;
            clr_n_q    <= clr_screen_d ? SCREEN_N : LINE_N;
            clr_cnt_q  <= 11'd1;
          end else begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
          end
        end
        ST_CLR: begin
          if (clr_cnt_q == clr_n_q) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= clr_base_q + clr_cnt_q;
            wr_data_q <= CH_BLANK;
            clr_cnt_q <= clr_cnt_q + 11'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready  = (state_q == ST_IDLE);
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_wr_cell_x = x_q;
  assign o_wr_cell_y = y_q;
  assign o_scroll    = scroll_q;
  assign o_cursor_h  = cursor_h_q;

endmodule
`default_nettype wire
